// File: rtl/fmac_vc_evt_gen_pkg.sv
// Shared FC MAC constants, primitive code lists and FSM state types for
// the VC event generator.
package fmac_vc_evt_gen_pkg;

  localparam int DATA_W = 32;

  localparam logic [31:0] PRIM_R_RDY     = 32'hBC4A_9595;
  localparam logic [15:0] PRIM_VC_RDY_HI = 16'hBCF5;

  localparam int N_SOF = 3;
  localparam int N_EOF = 2;
  localparam logic [N_SOF-1:0][15:0] SOF_CODES = {16'hBCB5, 16'hBC55, 16'hBC35};
  localparam logic [N_EOF-1:0][15:0] EOF_CODES = {16'hBC95, 16'hBC8A};

  typedef enum logic [1:0] {DOWN, LEARN, LOCKED} link_st_e;
  typedef enum logic [1:0] {IDLE, HDR0, HDR1} sof_st_e;

  function automatic logic is_sof_code(input logic [15:0] hi);
    is_sof_code = 1'b0;
    for (int i = 0; i < N_SOF; i++)
      if (hi == SOF_CODES[i]) is_sof_code = 1'b1;
  endfunction

  function automatic logic is_eof_code(input logic [15:0] hi);
    is_eof_code = 1'b0;
    for (int i = 0; i < N_EOF; i++)
      if (hi == EOF_CODES[i]) is_eof_code = 1'b1;
  endfunction

endpackage

// File: rtl/fmac_vc_evt_gen_if.sv
// Two-slot decoded word bus feeding the VC event generator (slot 0 older).
interface fmac_vc_evt_gen_if;
  logic [1:0]       slot_vld;
  logic [1:0]       slot_prim;
  logic [1:0][31:0] slot_data;

  modport master (output slot_vld, slot_prim, slot_data);
  modport slave  (input  slot_vld, slot_prim, slot_data);
endinterface

// File: rtl/fmac_prim_classify.sv
// Single-slot primitive classifier: R_RDY / VC_RDY events, SOF, EOF and data words.
// VC_RDY decode exists only when FMAC_VC_EN is defined.
module fmac_prim_classify
  import fmac_vc_evt_gen_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              vld,
  input  logic              prim,
  input  logic [DATA_W-1:0] data,
  output logic              evt,
  output logic [15:0]       evt_vc,
  output logic              sof,
  output logic              eof,
  output logic              word
);

  logic kchar;
  logic rrdy;

  assign kchar = vld & prim;
  assign rrdy  = kchar && (data == PRIM_R_RDY);

`ifdef FMAC_VC_EN
  logic vcrdy;
  // A VC_RDY carries its VC_ID twice; disagreeing copies mean a corrupted word.
  assign vcrdy  = kchar && (data[31:16] == PRIM_VC_RDY_HI) && (data[15:8] == data[7:0]);
  assign evt    = rrdy | vcrdy;
  assign evt_vc = vcrdy ? {8'h00, data[15:8]} : 16'h0000;
`else
  assign evt    = rrdy;
  assign evt_vc = 16'h0000;
`endif

  assign sof  = kchar && is_sof_code(data[31:16]);
  assign eof  = kchar && is_eof_code(data[31:16]);
  assign word = vld & ~prim;

endmodule

// File: rtl/fmac_vc_evt_gen.sv
// FC MAC link/VC event generator: R_RDY/VC_RDY events, VC_ID learning and SOF header
// CS_CTL capture over a two-slot word bus. Optional feature macro: FMAC_VC_EN.
module fmac_vc_evt_gen
  import fmac_vc_evt_gen_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  fmac_vc_evt_gen_if.slave     slot,
  input  logic                 link_up,
  output logic [1:0][15:0]     vc_id,
  output logic [1:0]           pair_vc_rdy_event,
  output logic [1:0]           vc_id_ld,
  output logic                 reg_sof_cnt_en,
  output logic [15:0]          sof_vc_id,
  output logic                 reg_link_up_cnt_en
);

  logic [1:0]       evt, sof, eof, word;
  logic [1:0][15:0] evt_vc;

  for (genvar i = 0; i < 2; i++) begin : g_cls
    fmac_prim_classify #(.DATA_W(DATA_W)) u_cls (
      .vld    (slot.slot_vld[i]),
      .prim   (slot.slot_prim[i]),
      .data   (slot.slot_data[i]),
      .evt    (evt[i]),
      .evt_vc (evt_vc[i]),
      .sof    (sof[i]),
      .eof    (eof[i]),
      .word   (word[i])
    );
  end

  link_st_e         link_st, link_nxt;
  sof_st_e          sof_st, sof_nxt;
  logic             active;
  logic [1:0]       evt_q, ld_q;
  logic             cap, lu_pls;
`ifdef FMAC_VC_EN
  logic [7:0]       cap_cs;
`endif

  always_comb begin
    link_nxt = link_st;
    sof_nxt  = sof_st;
    evt_q    = 2'b00;
    ld_q     = 2'b00;
    cap      = 1'b0;
    lu_pls   = 1'b0;
`ifdef FMAC_VC_EN
    cap_cs   = 8'h00;
`endif
    active   = link_up && (link_st != DOWN);

    if (active) begin
      evt_q = evt;
      if (link_st == LEARN) ld_q = evt[0] ? 2'b01 : {evt[1], 1'b0};
      // Walk slots oldest first so SOF and header words in one cycle keep their order.
      for (int i = 0; i < 2; i++) begin
        if (sof[i]) begin
          sof_nxt = HDR0;
        end else if (eof[i]) begin
          sof_nxt = IDLE;
        end else if (word[i]) begin
          if (sof_nxt == HDR0) begin
            sof_nxt = HDR1;
          end else if (sof_nxt == HDR1) begin
            sof_nxt = IDLE;
            cap     = 1'b1;
`ifdef FMAC_VC_EN
            cap_cs  = slot.slot_data[i][31:24];
`endif
          end
        end
      end
    end else begin
      sof_nxt = IDLE;
    end

    case (link_st)
      DOWN:    if (link_up) begin link_nxt = LEARN; lu_pls = 1'b1; end
      LEARN:   if (!link_up) link_nxt = DOWN; else if (|evt) link_nxt = LOCKED;
      LOCKED:  if (!link_up) link_nxt = DOWN;
      default: link_nxt = DOWN;
    endcase
  end

  // ---- p1: registered outputs ----
  logic [1:0][15:0] vc_id_p1;
  logic [1:0]       evt_p1, ld_p1;
  logic             sof_cnt_p1, lu_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      link_st    <= DOWN;
      sof_st     <= IDLE;
      vc_id_p1   <= '0;
      evt_p1     <= 2'b00;
      ld_p1      <= 2'b00;
      sof_cnt_p1 <= 1'b0;
      lu_p1      <= 1'b0;
    end else begin
      link_st    <= link_nxt;
      sof_st     <= sof_nxt;
      evt_p1     <= evt_q;
      ld_p1      <= ld_q;
      sof_cnt_p1 <= cap;
      lu_p1      <= lu_pls;
      for (int i = 0; i < 2; i++)
        if (evt_q[i]) vc_id_p1[i] <= evt_vc[i];
    end
  end

`ifdef FMAC_VC_EN
  logic [15:0] sof_vc_p1;
  always_ff @(posedge clk) begin
    if (rst)      sof_vc_p1 <= 16'h0000;
    else if (cap) sof_vc_p1 <= {8'h00, cap_cs};
  end
  assign sof_vc_id = sof_vc_p1;
`else
  assign sof_vc_id = 16'h0000;
`endif

  assign vc_id              = vc_id_p1;
  assign pair_vc_rdy_event  = evt_p1;
  assign vc_id_ld           = ld_p1;
  assign reg_sof_cnt_en     = sof_cnt_p1;
  assign reg_link_up_cnt_en = lu_p1;

endmodule

// File: tb/tb_fmac_vc_evt_gen.sv
// Bench for fmac_vc_evt_gen: directed vector table, VC_RDY sequences and random
// traffic checked against a word-stream reference model.
module tb_fmac_vc_evt_gen;

`ifdef FMAC_VC_EN
  localparam bit VC = 1'b1;
`else
  localparam bit VC = 1'b0;
`endif

  localparam logic [31:0] RR = 32'hBC4A_9595;
  localparam logic [31:0] SF = 32'hBCB5_5656;
  localparam logic [31:0] EF = 32'hBC95_7575;
  localparam logic [31:0] W0 = 32'h1234_5678;
  localparam logic [31:0] Z  = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst, link_up;
  logic [1:0][15:0] vc_id;
  logic [1:0] pair_vc_rdy_event, vc_id_ld;
  logic reg_sof_cnt_en, reg_link_up_cnt_en;
  logic [15:0] sof_vc_id;

  always #5 clk = ~clk;

  fmac_vc_evt_gen_if sif ();

  fmac_vc_evt_gen dut (
    .clk                (clk),
    .rst                (rst),
    .slot               (sif.slave),
    .link_up            (link_up),
    .vc_id              (vc_id),
    .pair_vc_rdy_event  (pair_vc_rdy_event),
    .vc_id_ld           (vc_id_ld),
    .reg_sof_cnt_en     (reg_sof_cnt_en),
    .sof_vc_id          (sof_vc_id),
    .reg_link_up_cnt_en (reg_link_up_cnt_en)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] actual=%0h required=%0h", nm, idx, act, exp);
    end
  endtask

  // Reference model: link stage 0=down 1=learning 2=locked; hdr -1=idle,
  // 0=waiting header word 0, 1=waiting header word 1.
  int               m_link = 0;
  int               m_hdr  = -1;
  logic [1:0][15:0] e_vc   = '0;
  logic [1:0]       e_evt, e_ld;
  logic             e_sof, e_lu;
  logic [15:0]      e_sofvc = 16'h0;

  function automatic bit is_sof_hi(input logic [15:0] h);
    return (h == 16'hBCB5) || (h == 16'hBC55) || (h == 16'hBC35);
  endfunction

  function automatic bit is_eof_hi(input logic [15:0] h);
    return (h == 16'hBC95) || (h == 16'hBC8A);
  endfunction

  task automatic model_step(input logic r, input logic lu, input logic [1:0] v, input logic [1:0] p,
                            input logic [31:0] d0, input logic [31:0] d1);
    logic [31:0] d [2];
    bit act;
    d[0] = d0;
    d[1] = d1;
    e_evt = 2'b00; e_ld = 2'b00; e_sof = 1'b0; e_lu = 1'b0;
    if (r) begin
      m_link = 0; m_hdr = -1; e_vc = '0; e_sofvc = 16'h0;
      return;
    end
    act = lu && (m_link != 0);
    for (int i = 0; i < 2; i++) begin
      bit k;
      k = v[i] && p[i];
      if (act && k && d[i] == 32'hBC4A_9595) begin
        e_evt[i] = 1'b1; e_vc[i] = 16'h0;
      end else if (act && VC && k && d[i][31:16] == 16'hBCF5 && d[i][15:8] == d[i][7:0]) begin
        e_evt[i] = 1'b1; e_vc[i] = {8'h00, d[i][15:8]};
      end
    end
    if (m_link == 1) begin
      if (e_evt[0]) e_ld = 2'b01;
      else if (e_evt[1]) e_ld = 2'b10;
    end
    if (!act) m_hdr = -1;
    else begin
      for (int i = 0; i < 2; i++) begin
        bit k;
        k = v[i] && p[i];
        if (k && is_sof_hi(d[i][31:16])) m_hdr = 0;
        else if (k && is_eof_hi(d[i][31:16])) m_hdr = -1;
        else if (v[i] && !p[i] && m_hdr >= 0) begin
          if (m_hdr == 0) m_hdr = 1;
          else begin
            m_hdr = -1;
            e_sof = 1'b1;
            e_sofvc = VC ? {8'h00, d[i][31:24]} : 16'h0;
          end
        end
      end
    end
    if (!lu) m_link = 0;
    else if (m_link == 0) begin m_link = 1; e_lu = 1'b1; end
    else if (m_link == 1 && e_evt != 2'b00) m_link = 2;
  endtask

  task automatic apply(input logic r, input logic lu, input logic [1:0] v, input logic [1:0] p,
                       input logic [31:0] d0, input logic [31:0] d1);
    rst = r; link_up = lu;
    sif.slot_vld = v; sif.slot_prim = p;
    sif.slot_data[0] = d0; sif.slot_data[1] = d1;
    model_step(r, lu, v, p, d0, d1);
    @(posedge clk);
    #1;
    chk("m_vc_id", checks, 64'({vc_id[1], vc_id[0]}), 64'({e_vc[1], e_vc[0]}));
    chk("m_evt",   checks, 64'(pair_vc_rdy_event), 64'(e_evt));
    chk("m_ld",    checks, 64'(vc_id_ld), 64'(e_ld));
    chk("m_sof",   checks, 64'(reg_sof_cnt_en), 64'(e_sof));
    chk("m_sofvc", checks, 64'(sof_vc_id), 64'(e_sofvc));
    chk("m_lu",    checks, 64'(reg_link_up_cnt_en), 64'(e_lu));
  endtask

  typedef struct {
    logic r, lu;
    logic [1:0] v, p;
    logic [31:0] d0, d1;
    logic [1:0] evt, ld;
    logic sof, lupl;
    logic [15:0] svc;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic lu, input logic [1:0] v, input logic [1:0] p,
                     input logic [31:0] d0, input logic [31:0] d1, input logic [1:0] evt,
                     input logic [1:0] ld, input logic sof, input logic lupl, input logic [15:0] svc);
    vec_t t;
    t.r = r; t.lu = lu; t.v = v; t.p = p; t.d0 = d0; t.d1 = d1;
    t.evt = evt; t.ld = ld; t.sof = sof; t.lupl = lupl; t.svc = svc;
    tbl.push_back(t);
  endtask

  task automatic rnd_slot(output logic v, output logic p, output logic [31:0] d);
    logic [7:0] b;
    b = 8'($urandom);
    v = 1'b1; p = 1'b1;
    case ($urandom_range(0, 9))
      0: d = RR;
      1: d = {16'hBCF5, b, b};
      2: d = {16'hBCF5, b, b ^ 8'h01};
      3: case ($urandom_range(0, 2))
           0: d = 32'hBCB5_5656;
           1: d = 32'hBC55_3737;
           default: d = 32'hBC35_1717;
         endcase
      4: d = $urandom_range(0, 1) ? EF : 32'hBC8A_7575;
      5, 6, 7: begin p = 1'b0; d = $urandom; end
      8: begin v = 1'b0; p = 1'($urandom); d = $urandom; end
      default: d = {16'hBC4A, 16'($urandom)};
    endcase
  endtask

  initial begin
    // Directed vectors: {rst, link_up, vld, prim, d0, d1} -> {evt, ld, sof, link_up pulse, sof_vc_id(VC build)}
    add(1,1'b0,2'b00,2'b00,Z,Z,                   2'b00,2'b00,0,0,16'h0000);
    add(1,1'b1,2'b00,2'b00,Z,Z,                   2'b00,2'b00,0,0,16'h0000);
    add(0,1'b1,2'b00,2'b00,Z,Z,                   2'b00,2'b00,0,1,16'h0000);
    add(0,1'b1,2'b00,2'b00,Z,Z,                   2'b00,2'b00,0,0,16'h0000);
    add(0,1'b1,2'b10,2'b10,Z,RR,                  2'b10,2'b10,0,0,16'h0000);
    add(0,1'b1,2'b11,2'b11,RR,RR,                 2'b11,2'b00,0,0,16'h0000);
    add(0,1'b0,2'b11,2'b11,RR,RR,                 2'b00,2'b00,0,0,16'h0000);
    add(0,1'b1,2'b00,2'b00,Z,Z,                   2'b00,2'b00,0,1,16'h0000);
    add(0,1'b1,2'b11,2'b11,RR,RR,                 2'b11,2'b01,0,0,16'h0000);
    add(0,1'b1,2'b10,2'b10,Z,SF,                  2'b00,2'b00,0,0,16'h0000);
    add(0,1'b1,2'b11,2'b00,W0,32'h0A00_0000,      2'b00,2'b00,1,0,16'h000A);
    add(0,1'b1,2'b00,2'b00,Z,Z,                   2'b00,2'b00,0,0,16'h000A);
    add(0,1'b1,2'b11,2'b01,SF,W0,                 2'b00,2'b00,0,0,16'h000A);
    add(0,1'b1,2'b11,2'b01,SF,W0,                 2'b00,2'b00,0,0,16'h000A);
    add(0,1'b1,2'b01,2'b00,32'h0500_0000,Z,       2'b00,2'b00,1,0,16'h0005);
    add(0,1'b1,2'b00,2'b00,Z,Z,                   2'b00,2'b00,0,0,16'h0005);
    add(0,1'b1,2'b11,2'b11,SF,EF,                 2'b00,2'b00,0,0,16'h0005);
    add(0,1'b1,2'b11,2'b00,W0,32'h0700_0000,      2'b00,2'b00,0,0,16'h0005);
    add(0,1'b1,2'b11,2'b11,SF,RR,                 2'b10,2'b00,0,0,16'h0005);
    add(0,1'b1,2'b11,2'b10,W0,RR,                 2'b10,2'b00,0,0,16'h0005);
    add(0,1'b1,2'b11,2'b01,RR,32'h0300_0000,      2'b01,2'b00,1,0,16'h0003);
    add(0,1'b1,2'b11,2'b01,SF,W0,                 2'b00,2'b00,0,0,16'h0003);
    add(0,1'b0,2'b01,2'b00,32'h0900_0000,Z,       2'b00,2'b00,0,0,16'h0003);
    add(0,1'b1,2'b01,2'b00,32'h0900_0000,Z,       2'b00,2'b00,0,1,16'h0003);
    add(0,1'b1,2'b01,2'b00,32'h0900_0000,Z,       2'b00,2'b00,0,0,16'h0003);
    add(0,1'b1,2'b11,2'b01,SF,W0,                 2'b00,2'b00,0,0,16'h0003);
    add(1,1'b1,2'b01,2'b00,32'h0900_0000,Z,       2'b00,2'b00,0,0,16'h0000);
    add(0,1'b1,2'b01,2'b00,32'h0900_0000,Z,       2'b00,2'b00,0,1,16'h0000);
    add(0,1'b1,2'b01,2'b00,32'h0900_0000,Z,       2'b00,2'b00,0,0,16'h0000);

    foreach (tbl[i]) begin
      apply(tbl[i].r, tbl[i].lu, tbl[i].v, tbl[i].p, tbl[i].d0, tbl[i].d1);
      chk("t_evt",   i, 64'(pair_vc_rdy_event), 64'(tbl[i].evt));
      chk("t_ld",    i, 64'(vc_id_ld), 64'(tbl[i].ld));
      chk("t_sof",   i, 64'(reg_sof_cnt_en), 64'(tbl[i].sof));
      chk("t_lu",    i, 64'(reg_link_up_cnt_en), 64'(tbl[i].lupl));
      chk("t_sofvc", i, 64'(sof_vc_id), 64'(VC ? tbl[i].svc : 16'h0000));
      if (tbl[i].r)
        chk("t_rst_vc", i, 64'({vc_id[1], vc_id[0]}), 64'h0);
    end

    // Simultaneous VC_RDY while learning, then a repeat once locked.
    apply(0, 1'b1, 2'b11, 2'b11, 32'hBCF5_0707, 32'hBCF5_0303);
    chk("vc_evt", 0, 64'(pair_vc_rdy_event), 64'(VC ? 2'b11 : 2'b00));
    chk("vc_ld",  0, 64'(vc_id_ld), 64'(VC ? 2'b01 : 2'b00));
    chk("vc_id",  0, 64'({vc_id[1], vc_id[0]}), 64'(VC ? 32'h0003_0007 : 32'h0));
    apply(0, 1'b1, 2'b11, 2'b11, 32'hBCF5_0707, 32'hBCF5_0303);
    chk("vc_evt", 1, 64'(pair_vc_rdy_event), 64'(VC ? 2'b11 : 2'b00));
    chk("vc_ld",  1, 64'(vc_id_ld), 64'h0);

    // Bad VC_RDY is dropped and leaves the link learning.
    apply(0, 1'b0, 2'b00, 2'b00, Z, Z);
    apply(0, 1'b1, 2'b00, 2'b00, Z, Z);
    chk("relink", 0, 64'(reg_link_up_cnt_en), 64'h1);
    apply(0, 1'b1, 2'b01, 2'b01, 32'hBCF5_0708, Z);
    chk("bad_evt", 0, 64'(pair_vc_rdy_event), 64'h0);
    chk("bad_ld",  0, 64'(vc_id_ld), 64'h0);
    apply(0, 1'b1, 2'b01, 2'b01, RR, Z);
    chk("still_learn", 0, 64'(vc_id_ld), 64'h1);

    // Random traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      logic v0, p0, v1, p1;
      logic [31:0] d0, d1;
      rnd_slot(v0, p0, d0);
      rnd_slot(v1, p1, d1);
      apply(($urandom_range(0, 199) == 0), ($urandom_range(0, 79) != 0),
            {v1, v0}, {p1, p0}, d0, d1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
